mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Two-master arbiter sharing the single-port MEM array (sync write, async read) between the
//   processor datapath (M0) and a second bus master (M1: loader/debug/DMA). Round-robin grant,
//   one access per granted cycle, optional locked bursts capped at MAXBURST. Read data registered.
// PARAMETERS
//   DBITS     16  data width, matches MEM DBITS
//   ABITS     12  word-address width, matches MEM ABITS
//   MAXBURST  4   max consecutive grants to one master under LOCK (>=1)
// PORTS
//   CLK        in   1      clock, all state updates on rising edge
//   RESETN     in   1      asynchronous reset, active low
//   REQ0/REQ1  in   1      access request, held until GNTn seen
//   LOCK0/LOCK1 in  1      request to keep grant for next access (burst)
//   WE0/WE1    in   1      1=write, 0=read; stable while REQn
//   ADDR0/ADDR1 in  ABITS  word address; stable while REQn
//   WDATA0/WDATA1 in DBITS write data; stable while REQn
//   GNT0/GNT1  out  1      access performed this cycle for master n
//   RVALID0/RVALID1 out 1  RDATAn valid (one cycle pulse)
//   RDATA0/RDATA1 out DBITS registered read data
//   MEM_ADDR   out  ABITS  to MEM.ADDR
//   MEM_DIN    out  DBITS  to MEM.DIN
//   MEM_WE     out  1      to MEM.WE
//   MEM_DOUT   in   DBITS  from MEM.DOUT (combinational read)
// BEHAVIOUR
//   States: IDLE, BUSY0, BUSY1 (registered). LAST = last granted master; BCNT = grants in burst.
//   Reset (async, RESETN=0): state=IDLE, LAST=1 (M0 wins first tie), BCNT=0, GNTn=0, RVALIDn=0,
//     RDATAn=0. MEM_WE=0 immediately (combinational from state) -> in-flight write aborted.
//   GNTn = (state==BUSYn) && REQn. MEM_* driven from master n in BUSYn, else MEM_WE=0, ADDR/DIN=0.
//   MEM_WE = GNTn && WEn. REQn low in BUSYn (protocol violation): no write, no RVALID, no GNT.
//   Latency: REQ seen in IDLE at edge k -> GNTn in cycle k+1; read RDATAn/RVALIDn in cycle k+2.
//   Read: at GNT cycle edge RDATAn<=MEM_DOUT, RVALIDn<=1 for exactly one cycle; writes give no RVALID.
//   RDATAn holds last value between reads; RVALIDn=0 otherwise.
//   Next-state (evaluated every edge):
//     IDLE: none->IDLE; one REQ->BUSYn; both->BUSY(~LAST).
//     BUSYn: if LOCKn && REQn && BCNT<MAXBURST-1 -> BUSYn, BCNT++;
//            else if REQ(other) -> BUSY(other), BCNT=0;
//            else if REQn -> BUSYn, BCNT=0 (new burst, no contender);
//            else IDLE, BCNT=0.
//     LAST<=n on every GNTn edge. Back-to-back grants need no IDLE cycle.
//   Burst cap: with other master requesting, master n gets at most MAXBURST consecutive GNTs.
//   MAXBURST=1: LOCK ignored. BCNT width = max(1,$clog2(MAXBURST)); never wraps (cleared before cap).
//   Master advances ADDR/WDATA after each GNT cycle; arbiter does not store requests.
//   Same-cycle write by M0 and read by M1 impossible (one grant/cycle); write-then-read same
//   address in consecutive grants returns written data (MEM write commits at GNT edge).
// TESTING
//   1 M0 read addr 0x010 (mem=0xBEEF), M1 idle -> GNT0 cycle k+1, RVALID0+RDATA0=0xBEEF k+2.
//   2 REQ0,REQ1 both held after reset, no LOCK -> GNT0,GNT1,GNT0,GNT1 alternate every cycle.
//   3 LOCK0+REQ0 held, REQ1 held, MAXBURST=4 -> GNT0 x4, GNT1 x1, GNT0 x4 ...; BCNT never >3.
//   4 M1 write 0x5A5A @0x020 then M0 read 0x020 next grant -> RDATA0=0x5A5A, RVALID1 never set.
//   5 RESETN low during BUSY0 write -> MEM_WE=0 same cycle, GNT/RVALID=0, mem@addr unchanged, IDLE.
//   6 REQ0 dropped in BUSY0 cycle -> GNT0=0, MEM_WE=0, no RVALID0, state->IDLE next edge.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the single-port MEM array.
interface mem_arbiter_if #(
   parameter int unsigned DBITS = 16,
   parameter int unsigned ABITS = 12
);
   logic             req0;
   logic             req1;
   logic             lock0;
   logic             lock1;
   logic             we0;
   logic             we1;
   logic [ABITS-1:0] addr0;
   logic [ABITS-1:0] addr1;
   logic [DBITS-1:0] wdata0;
   logic [DBITS-1:0] wdata1;
   logic             gnt0;
   logic             gnt1;
   logic             rvalid0;
   logic             rvalid1;
   logic [DBITS-1:0] rdata0;
   logic [DBITS-1:0] rdata1;
   logic [ABITS-1:0] mem_addr;
   logic [DBITS-1:0] mem_din;
   logic             mem_we;
   logic [DBITS-1:0] mem_dout;

   modport slave (
      input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
      output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_addr, mem_din, mem_we
   );

   modport master (
      output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_addr, mem_din, mem_we
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin two-master arbiter for a single-port MEM (sync write, async read),
// with capped locked bursts and registered read data.
module mem_arbiter #(
   parameter int unsigned DBITS    = 16,
   parameter int unsigned ABITS    = 12,
   parameter int unsigned MAXBURST = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   mem_arbiter_if.slave   bus
);
   localparam int unsigned BW = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;
   localparam logic [BW-1:0] BCNT_CAP = BW'(MAXBURST - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY0 = 2'd1,
      BUSY1 = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic             last_q, last_d;
   logic [BW-1:0]    bcnt_q, bcnt_d;
   logic             rvalid0_q, rvalid0_d;
   logic             rvalid1_q, rvalid1_d;
   logic [DBITS-1:0] rdata0_q, rdata0_d;
   logic [DBITS-1:0] rdata1_q, rdata1_d;
   logic             gnt0_c;
   logic             gnt1_c;

   // Grant and MEM drive follow the state directly so reset kills a write at once.
   always_comb begin
      gnt0_c = (state_q == BUSY0) && bus.req0;
      gnt1_c = (state_q == BUSY1) && bus.req1;
   end

   assign bus.gnt0     = gnt0_c;
   assign bus.gnt1     = gnt1_c;
   assign bus.mem_we   = (gnt0_c && bus.we0) || (gnt1_c && bus.we1);
   assign bus.mem_addr = (state_q == BUSY0) ? bus.addr0 :
                         (state_q == BUSY1) ? bus.addr1 : '0;
   assign bus.mem_din  = (state_q == BUSY0) ? bus.wdata0 :
                         (state_q == BUSY1) ? bus.wdata1 : '0;
   assign bus.rvalid0  = rvalid0_q;
   assign bus.rvalid1  = rvalid1_q;
   assign bus.rdata0   = rdata0_q;
   assign bus.rdata1   = rdata1_q;

   always_comb begin
      state_d   = state_q;
      bcnt_d    = '0;
      last_d    = last_q;
      rvalid0_d = 1'b0;
      rvalid1_d = 1'b0;
      rdata0_d  = rdata0_q;
      rdata1_d  = rdata1_q;

      if (gnt0_c) last_d = 1'b0;
      if (gnt1_c) last_d = 1'b1;

      if (gnt0_c && !bus.we0) begin
         rvalid0_d = 1'b1;
         rdata0_d  = bus.mem_dout;
      end
      if (gnt1_c && !bus.we1) begin
         rvalid1_d = 1'b1;
         rdata1_d  = bus.mem_dout;
      end

      case (state_q)
         IDLE: begin
            if (bus.req0 && bus.req1) state_d = last_q ? BUSY0 : BUSY1;
            else if (bus.req0)        state_d = BUSY0;
            else if (bus.req1)        state_d = BUSY1;
         end
         BUSY0: begin
            // Locked burst continues only below the cap; the counter never wraps.
            if (bus.lock0 && bus.req0 && (bcnt_q < BCNT_CAP)) begin
               state_d = BUSY0;
               bcnt_d  = bcnt_q + BW'(1);
            end else if (bus.req1) state_d = BUSY1;
            else if (bus.req0)     state_d = BUSY0;
            else                   state_d = IDLE;
         end
         BUSY1: begin
            if (bus.lock1 && bus.req1 && (bcnt_q < BCNT_CAP)) begin
               state_d = BUSY1;
               bcnt_d  = bcnt_q + BW'(1);
            end else if (bus.req0) state_d = BUSY0;
            else if (bus.req1)     state_d = BUSY1;
            else                   state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         last_q    <= 1'b1;
         bcnt_q    <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         bcnt_q    <= bcnt_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural sync-write/async-read memory.
module tb_mem_arbiter;
   localparam int unsigned DBITS = 16;
   localparam int unsigned ABITS = 12;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mem_arbiter_if #(.DBITS(DBITS), .ABITS(ABITS)) bus ();

   mem_arbiter #(.DBITS(DBITS), .ABITS(ABITS), .MAXBURST(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [DBITS-1:0] mem [1 << ABITS];
   logic             pre_we;
   logic [ABITS-1:0] pre_addr;
   logic [DBITS-1:0] pre_data;

   always @(posedge clk) begin
      if (pre_we)          mem[pre_addr]     <= pre_data;
      else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
   end
   assign bus.mem_dout = mem[bus.mem_addr];

   int n_chk  = 0;
   int n_fail = 0;
   int exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic [ABITS-1:0] a, input logic [DBITS-1:0] d);
      pre_addr = a;
      pre_data = d;
      pre_we   = 1'b1;
      tick();
      pre_we   = 1'b0;
   endtask

   task automatic idle_inputs();
      bus.req0 = 1'b0;  bus.req1 = 1'b0;
      bus.lock0 = 1'b0; bus.lock1 = 1'b0;
      bus.we0 = 1'b0;   bus.we1 = 1'b0;
      bus.addr0 = '0;   bus.addr1 = '0;
      bus.wdata0 = '0;  bus.wdata1 = '0;
   endtask

   initial begin
      idle_inputs();
      pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      rst_n = 1'b0;
      #12;
      chk("rst_gnt0", bus.gnt0, 0);
      chk("rst_gnt1", bus.gnt1, 0);
      chk("rst_rvalid0", bus.rvalid0, 0);
      chk("rst_rvalid1", bus.rvalid1, 0);
      chk("rst_rdata0", bus.rdata0, 0);
      chk("rst_rdata1", bus.rdata1, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      poke(12'h010, 16'hBEEF);
      poke(12'h030, 16'h0F0F);
      chk("idle_mem_addr", bus.mem_addr, 0);

      // Single read by M0, then REQ0 dropped while still in BUSY0
      bus.req0 = 1'b1; bus.addr0 = 12'h010;
      tick();
      chk("t1_gnt0", bus.gnt0, 1);
      chk("t1_mem_addr", bus.mem_addr, 32'h010);
      chk("t1_mem_we", bus.mem_we, 0);
      chk("t1_rvalid0_early", bus.rvalid0, 0);
      tick();
      chk("t1_rvalid0", bus.rvalid0, 1);
      chk("t1_rdata0", bus.rdata0, 32'hBEEF);
      bus.req0 = 1'b0;
      #1;
      chk("t6_gnt0_drop", bus.gnt0, 0);
      chk("t6_mem_we_drop", bus.mem_we, 0);
      tick();
      chk("t6_no_rvalid0", bus.rvalid0, 0);
      bus.req0 = 1'b1;
      #1;
      chk("t6_idle_no_gnt", bus.gnt0, 0);
      bus.req0 = 1'b0;
      tick();

      // Both masters request right after reset: strict alternation starting at M0
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      bus.req0 = 1'b1; bus.addr0 = 12'h010;
      bus.req1 = 1'b1; bus.addr1 = 12'h030;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("t2_gnt0_%0d", i), bus.gnt0, (i % 2 == 0) ? 1 : 0);
         chk($sformatf("t2_gnt1_%0d", i), bus.gnt1, (i % 2 == 1) ? 1 : 0);
         chk($sformatf("t2_rvalid0_%0d", i), bus.rvalid0, (i % 2 == 1) ? 1 : 0);
         chk($sformatf("t2_rvalid1_%0d", i), bus.rvalid1, (i == 2) ? 1 : 0);
      end
      tick();
      chk("t2_rvalid1_end", bus.rvalid1, 1);
      chk("t2_rdata1", bus.rdata1, 32'h0F0F);
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      tick();

      // Locked M0 burst against a waiting M1: four grants, then one for M1
      bus.req0 = 1'b1; bus.lock0 = 1'b1; bus.req1 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("t3_gnt0_%0d", i), bus.gnt0, (exp_seq[i] == 0) ? 1 : 0);
         chk($sformatf("t3_gnt1_%0d", i), bus.gnt1, (exp_seq[i] == 1) ? 1 : 0);
      end
      idle_inputs();
      tick();
      tick();

      // M1 write then M0 read of the same word on the next grant
      bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 12'h020; bus.wdata1 = 16'h5A5A;
      tick();
      chk("t4_gnt1", bus.gnt1, 1);
      chk("t4_mem_we", bus.mem_we, 1);
      chk("t4_mem_addr", bus.mem_addr, 32'h020);
      chk("t4_mem_din", bus.mem_din, 32'h5A5A);
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 12'h020;
      tick();
      chk("t4_gnt0", bus.gnt0, 1);
      chk("t4_gnt1_off", bus.gnt1, 0);
      chk("t4_mem_dout", bus.mem_dout, 32'h5A5A);
      chk("t4_rvalid1_a", bus.rvalid1, 0);
      bus.req1 = 1'b0; bus.we1 = 1'b0;
      tick();
      chk("t4_rvalid0", bus.rvalid0, 1);
      chk("t4_rdata0", bus.rdata0, 32'h5A5A);
      chk("t4_rvalid1_b", bus.rvalid1, 0);
      bus.req0 = 1'b0;
      tick();
      chk("t4_rvalid1_c", bus.rvalid1, 0);

      // Reset asserted in the middle of an M0 write cycle
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 12'h030; bus.wdata0 = 16'h1234;
      tick();
      chk("t5_gnt0", bus.gnt0, 1);
      chk("t5_mem_we", bus.mem_we, 1);
      rst_n = 1'b0;
      #1;
      chk("t5_mem_we_rst", bus.mem_we, 0);
      chk("t5_gnt0_rst", bus.gnt0, 0);
      chk("t5_rvalid0_rst", bus.rvalid0, 0);
      bus.req0 = 1'b0; bus.we0 = 1'b0;
      tick();
      chk("t5_mem_kept", mem[12'h030], 32'h0F0F);
      chk("t5_rdata0_rst", bus.rdata0, 0);
      rst_n = 1'b1;
      bus.req0 = 1'b1; bus.addr0 = 12'h030;
      #1;
      chk("t5_idle_no_gnt", bus.gnt0, 0);
      tick();
      chk("t5_gnt0_after", bus.gnt0, 1);
      tick();
      chk("t5_rvalid0_after", bus.rvalid0, 1);
      chk("t5_rdata0_after", bus.rdata0, 32'h0F0F);
      bus.req0 = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
